// File: rtl/cel_row_sequencer.sv
// Walks one packed cel row by row: loads DMA, kicks the unpacker, turns pixels into framebuffer writes.
// Optional per-row watchdog enabled by defining CEL_ROW_WATCHDOG_EN.
module cel_row_sequencer #(
  parameter int ADDR_W   = 22,
  parameter int XW       = 11,
  parameter int WD_LIMIT = 4095
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cel_start,
  input  logic [ADDR_W-1:0] cel_addr,
  input  logic [XW-1:0]     cel_rows,
  input  logic [3:0]        cel_skipx,
  input  logic              abort,
  output logic              busy,
  output logic              cel_done,
  output logic [ADDR_W-1:0] dma_addr,
  output logic              dma_load,
  output logic              up_start,
  input  logic              up_pix_valid,
  input  logic              up_transp,
  input  logic [15:0]       up_col,
  input  logic              up_eol,
  input  logic [9:0]        up_offset,
  output logic              pix_we,
  output logic [XW-1:0]     pix_x,
  output logic [XW-1:0]     pix_y,
  output logic [15:0]       pix_col,
  output logic              err_timeout
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_KICK, S_RUN, S_NEXT, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] row_addr;
  logic [XW-1:0]     rows, x, y;
  logic [3:0]        skipx, skip_cnt;
  logic [9:0]        off_lat;
  logic              abort_act, wd_hit, pix_take, pix_skip, pix_fire, last_row;

  if (WD_LIMIT < 1) begin : g_wd_range
    $error("WD_LIMIT must be at least 1");
  end

  assign abort_act = abort && (state != S_IDLE);
  assign pix_take  = (state == S_RUN) && up_pix_valid && !abort_act;
  assign pix_skip  = skip_cnt < skipx;
  assign pix_fire  = pix_take && !pix_skip && !up_transp;
  assign last_row  = (XW'(y + 1'b1) == rows);

`ifdef CEL_ROW_WATCHDOG_EN
  localparam int WDW = $clog2(WD_LIMIT + 1);
  logic [WDW-1:0] wd_cnt;

  // Counter sits at zero outside RUN, so it is clear on every RUN entry.
  assign wd_hit = (state == S_RUN) && !up_eol && (wd_cnt == WDW'(WD_LIMIT - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      wd_cnt      <= (state == S_RUN) ? wd_cnt + 1'b1 : '0;
      err_timeout <= wd_hit && !abort_act;
    end
  end
`else
  assign wd_hit      = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (cel_start) state_nxt = (cel_rows == '0) ? S_DONE : S_LOAD;
      S_LOAD: state_nxt = S_KICK;
      S_KICK: state_nxt = S_RUN;
      S_RUN: begin
        if (up_eol)      state_nxt = S_NEXT;
        else if (wd_hit) state_nxt = S_IDLE;
      end
      S_NEXT: state_nxt = last_row ? S_DONE : S_LOAD;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort_act) state_nxt = S_IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_addr <= '0;
      rows     <= '0;
      skipx    <= '0;
      skip_cnt <= '0;
      x        <= '0;
      y        <= '0;
      off_lat  <= '0;
      busy     <= 1'b0;
      cel_done <= 1'b0;
      dma_addr <= '0;
      dma_load <= 1'b0;
      up_start <= 1'b0;
      pix_we   <= 1'b0;
      pix_x    <= '0;
      pix_y    <= '0;
      pix_col  <= '0;
    end else begin
      cel_done <= (state == S_DONE) && !abort_act;
      dma_load <= (state == S_LOAD) && !abort_act;
      up_start <= (state == S_KICK) && !abort_act;
      pix_we   <= pix_fire;

      case (state)
        S_IDLE: if (cel_start) begin
          row_addr <= cel_addr;
          rows     <= cel_rows;
          skipx    <= cel_skipx;
          y        <= '0;
          busy     <= 1'b1;
        end
        S_LOAD: begin
          dma_addr <= row_addr;
          x        <= '0;
          skip_cnt <= '0;
        end
        S_RUN: begin
          if (pix_take) begin
            if (pix_skip) skip_cnt <= skip_cnt + 1'b1;
            else if (!(&x)) x <= x + 1'b1;
          end
          if (up_eol) off_lat <= up_offset;
          if (wd_hit) busy <= 1'b0;
        end
        S_NEXT: begin
          row_addr <= row_addr + ADDR_W'(off_lat) + ADDR_W'(2);
          y        <= y + 1'b1;
        end
        S_DONE: busy <= 1'b0;
        default: ;
      endcase

      if (pix_fire) begin
        pix_x   <= x;
        pix_y   <= y;
        pix_col <= up_col;
      end

      if (abort_act) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cel_row_sequencer.sv
// Directed bench for cel_row_sequencer: row walk, skip-X, transparency, empty cel, abort, watchdog.
module tb_cel_row_sequencer;
  localparam int ADDR_W = 22;
  localparam int XW     = 11;

  logic              clock = 1'b0, reset_n = 1'b0;
  logic              cel_start = 1'b0, abort = 1'b0;
  logic [ADDR_W-1:0] cel_addr = '0;
  logic [XW-1:0]     cel_rows = '0;
  logic [3:0]        cel_skipx = '0;
  logic              busy, cel_done, dma_load, up_start, pix_we, err_timeout;
  logic [ADDR_W-1:0] dma_addr;
  logic              up_pix_valid = 1'b0, up_transp = 1'b0, up_eol = 1'b0;
  logic [15:0]       up_col = '0;
  logic [9:0]        up_offset = '0;
  logic [XW-1:0]     pix_x, pix_y;
  logic [15:0]       pix_col;

  int tests = 0, fails = 0;

  cel_row_sequencer #(.ADDR_W(ADDR_W), .XW(XW), .WD_LIMIT(16)) dut (
    .clock(clock), .reset_n(reset_n), .cel_start(cel_start), .cel_addr(cel_addr),
    .cel_rows(cel_rows), .cel_skipx(cel_skipx), .abort(abort), .busy(busy),
    .cel_done(cel_done), .dma_addr(dma_addr), .dma_load(dma_load), .up_start(up_start),
    .up_pix_valid(up_pix_valid), .up_transp(up_transp), .up_col(up_col), .up_eol(up_eol),
    .up_offset(up_offset), .pix_we(pix_we), .pix_x(pix_x), .pix_y(pix_y),
    .pix_col(pix_col), .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic pix(input logic v, input logic t, input logic [15:0] c, input logic e, input logic [9:0] o);
    up_pix_valid = v; up_transp = t; up_col = c; up_eol = e; up_offset = o;
  endtask

  task automatic chk_wr(input string tag, input logic [XW-1:0] ex, input logic [XW-1:0] ey, input logic [15:0] ec);
    chk({tag, "_we"}, 32'(pix_we), 32'd1);
    chk({tag, "_x"}, 32'(pix_x), 32'(ex));
    chk({tag, "_y"}, 32'(pix_y), 32'(ey));
    chk({tag, "_col"}, 32'(pix_col), 32'(ec));
  endtask

  // Issue cel_start and walk through LOAD/KICK; returns in the first RUN cycle.
  task automatic start_cel(input string tag, input logic [ADDR_W-1:0] a, input logic [XW-1:0] r, input logic [3:0] s);
    cel_addr = a; cel_rows = r; cel_skipx = s; cel_start = 1'b1;
    tick; cel_start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    tick;
    chk({tag, "_dma_load"}, 32'(dma_load), 32'd1);
    chk({tag, "_dma_addr"}, 32'(dma_addr), 32'(a));
    tick;
    chk({tag, "_up_start"}, 32'(up_start), 32'd1);
  endtask

  initial begin
    // reset values
    tick;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(cel_done), 0);
    chk("rst_dma_load", 32'(dma_load), 0);
    chk("rst_dma_addr", 32'(dma_addr), 0);
    chk("rst_up_start", 32'(up_start), 0);
    chk("rst_pix_we", 32'(pix_we), 0);
    chk("rst_err", 32'(err_timeout), 0);
    reset_n = 1'b1;
    tick;

    // 1: two rows, three opaque pixels, eol together with last pixel
    start_cel("t1r0", 22'h1000, 11'd2, 4'd0);
    pix(1, 0, 16'h11, 0, 0); tick; chk_wr("t1p0", 0, 0, 16'h11);
    pix(1, 0, 16'h22, 0, 0); tick; chk_wr("t1p1", 1, 0, 16'h22);
    pix(1, 0, 16'h33, 1, 10'd4); tick; chk_wr("t1p2", 2, 0, 16'h33);
    pix(0, 0, 0, 0, 0);
    tick; chk("t1_idle_we", 32'(pix_we), 0);
    tick;
    chk("t1r1_dma_load", 32'(dma_load), 1);
    chk("t1r1_dma_addr", 32'(dma_addr), 32'h1006);
    tick; chk("t1r1_up_start", 32'(up_start), 1);
    pix(1, 0, 16'h44, 0, 0); tick; chk_wr("t1r1p0", 0, 1, 16'h44);
    pix(0, 0, 0, 1, 0); tick; pix(0, 0, 0, 0, 0);
    chk("t1_busy_next", 32'(busy), 1);
    tick; chk("t1_done_early", 32'(cel_done), 0);
    tick;
    chk("t1_done", 32'(cel_done), 1);
    chk("t1_busy_done", 32'(busy), 0);
    tick; chk("t1_done_pulse", 32'(cel_done), 0);

    // 2: skipx=2 drops A and B
    start_cel("t2", 22'h0200, 11'd1, 4'd2);
    pix(1, 0, 16'hA, 0, 0); tick; chk("t2_skipA", 32'(pix_we), 0);
    pix(1, 0, 16'hB, 0, 0); tick; chk("t2_skipB", 32'(pix_we), 0);
    pix(1, 0, 16'hC, 0, 0); tick; chk_wr("t2C", 0, 0, 16'hC);
    pix(1, 0, 16'hD, 0, 0); tick; chk_wr("t2D", 1, 0, 16'hD);
    pix(1, 0, 16'hE, 1, 0); tick; chk_wr("t2E", 2, 0, 16'hE);
    pix(0, 0, 0, 0, 0);
    tick; tick; chk("t2_done", 32'(cel_done), 1);
    tick;

    // 3: opaque, transparent, opaque
    start_cel("t3", 22'h0300, 11'd1, 4'd0);
    pix(1, 0, 16'h5, 0, 0); tick; chk_wr("t3p0", 0, 0, 16'h5);
    pix(1, 1, 16'h6, 0, 0); tick; chk("t3_transp", 32'(pix_we), 0);
    pix(1, 0, 16'h7, 1, 0); tick; chk_wr("t3p2", 2, 0, 16'h7);
    pix(0, 0, 0, 0, 0);
    tick; tick; chk("t3_done", 32'(cel_done), 1);
    tick;

    // 4: empty cel
    cel_addr = 22'h0400; cel_rows = 11'd0; cel_start = 1'b1;
    tick; cel_start = 1'b0;
    chk("t4_busy", 32'(busy), 1);
    chk("t4_no_load", 32'(dma_load), 0);
    chk("t4_done_early", 32'(cel_done), 0);
    tick;
    chk("t4_done", 32'(cel_done), 1);
    chk("t4_busy_done", 32'(busy), 0);
    chk("t4_no_load2", 32'(dma_load), 0);
    chk("t4_no_kick", 32'(up_start), 0);
    tick;

    // 5: abort during row 1 of 4; start while busy is ignored
    start_cel("t5", 22'h2000, 11'd4, 4'd0);
    pix(0, 0, 0, 1, 0); tick; pix(0, 0, 0, 0, 0);
    tick; tick;
    chk("t5r1_dma_addr", 32'(dma_addr), 32'h2002);
    tick;
    cel_addr = 22'h3000; cel_start = 1'b1;
    pix(1, 0, 16'h99, 0, 0); tick; cel_start = 1'b0;
    chk_wr("t5p0", 0, 1, 16'h99);
    chk("t5_busy_ignore", 32'(busy), 1);
    pix(0, 0, 0, 0, 0); abort = 1'b1;
    tick; abort = 1'b0;
    chk("t5_abort_busy", 32'(busy), 0);
    chk("t5_abort_done", 32'(cel_done), 0);
    tick;
    chk("t5_idle_load", 32'(dma_load), 0);
    chk("t5_idle_done", 32'(cel_done), 0);
    chk("t5_idle_busy", 32'(busy), 0);

    // asynchronous reset mid-cel
    start_cel("trst", 22'h0500, 11'd3, 4'd0);
    pix(1, 0, 16'h1, 0, 0); #2 reset_n = 1'b0; #1;
    chk("trst_busy", 32'(busy), 0);
    chk("trst_we", 32'(pix_we), 0);
    chk("trst_dma_addr", 32'(dma_addr), 0);
    pix(0, 0, 0, 0, 0);
    tick; reset_n = 1'b1; tick;
    chk("trst_idle", 32'(busy), 0);

    // 6: watchdog, no eol
    start_cel("t6", 22'h0600, 11'd1, 4'd0);
    for (int i = 1; i < 16; i++) tick;
    chk("t6_err_early", 32'(err_timeout), 0);
    tick;
`ifdef CEL_ROW_WATCHDOG_EN
    chk("t6_err", 32'(err_timeout), 1);
    chk("t6_busy", 32'(busy), 0);
    tick;
    chk("t6_err_pulse", 32'(err_timeout), 0);
    chk("t6_no_done", 32'(cel_done), 0);
`else
    chk("t6_err_off", 32'(err_timeout), 0);
    chk("t6_busy_held", 32'(busy), 1);
    abort = 1'b1; tick; abort = 1'b0;
    chk("t6_abort", 32'(busy), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
